// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the MiniCore register file, the decode stage and
// the writeback path.
//   clr_state_t  - clear-sequencer state encoding (IDLE=0, CLEAR=1)
//   DEF_DATA_W   - default register width
//   DEF_ADDR_W   - default register address width
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq
// Sequencer that zeroes every register, one entry per cycle.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   clear_req in   start request (only looked at while IDLE)
//   busy      out  high for exactly DEPTH cycles while clearing
//   clr_en    out  clear the entry at clr_addr on this edge
//   clr_addr  out  entry being cleared this cycle
//   state     out  current sequencer state (debug/observation)
//
// Handshake: clear_req is a request with no acknowledge. It is sampled on
// each rising edge while IDLE; busy rises on the following cycle. Requests
// seen while CLEAR are ignored, so a sequence is never restarted or extended.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output clr_state_t        state
);

    // Address of the final entry (DEPTH-1).
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // The counter wraps to zero after the last entry, which
                // leaves it ready for the next sequence.
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_en   = (state_q == CLEAR);
    assign clr_addr = cnt_q;
    assign state    = state_q;

endmodule

// File: rtl/regfile_param.sv
// regfile_param
// Parametrised two-read / one-write register file with registered reads,
// an optional hardwired zero register, optional write-first bypass, a read
// hold (stall) and a sequential software clear.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset (clears everything)
//   rs, rt     in   read addresses for ports 1 and 2
//   rd         in   write address
//   writedata  in   write data
//   write_reg  in   write enable (dropped while a clear is running)
//   stall      in   hold readdat1/readdat2
//   clear_req  in   start a clear of all DEPTH registers
//   busy       out  clear in progress
//   readdat1/2 out  read data, one cycle after the address
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] writedata,
    input  logic              write_reg,
    input  logic              stall,
    input  logic              clear_req,
    output logic              busy,
    output logic [DATA_W-1:0] readdat1,
    output logic [DATA_W-1:0] readdat2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    clr_state_t        clr_state;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              rd_is_zero;
    logic              wr_acc;
    logic [DATA_W-1:0] val1, val2;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr),
        .state     (clr_state)
    );

    // Writes are only taken while the sequencer is idle, and never to the
    // hardwired zero register.
    assign rd_is_zero = (ZERO_REG != 0) && (rd == '0);
    assign wr_acc     = write_reg && (clr_state == IDLE) && !rd_is_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem[rd] <= writedata;
        end
    end

    // Value presented to the read registers. With bypass enabled a write
    // accepted on this same edge is forwarded (write-first); otherwise the
    // pre-edge contents are returned (read-old).
    always_comb begin
        val1 = mem[rs];
        val2 = mem[rt];
        if (BYPASS != 0 && wr_acc && rd == rs) val1 = writedata;
        if (BYPASS != 0 && wr_acc && rd == rt) val2 = writedata;
        if (ZERO_REG != 0 && rs == '0) val1 = '0;
        if (ZERO_REG != 0 && rt == '0) val2 = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdat1 <= '0;
            readdat2 <= '0;
        end else if (!stall) begin
            readdat1 <= val1;
            readdat2 <= val2;
        end
    end

endmodule
